voice_sequencer: RTL

Two-channel step sequencer that drives the SID-style voice pair. It owns tempo, step position, bar position, gating and pulse-width sweep. It reads note/accent data from a pattern ROM and presents per-voice note index (to the scale ROM), control byte and pulse width. It sits between the 1 MHz audio tick generator and the two voice instances, replacing ad-hoc counter-bit note logic.

---
 rtl/audio_seq_pkg.sv | 23 ++
 rtl/pattern_rom.sv | 19 +
 rtl/voice_sequencer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/audio_seq_pkg.sv
// audio_seq_pkg: shared constants, ROM entry layout and FSM states for the voice sequencer.
package audio_seq_pkg;
    localparam logic [3:0] REST_NOTE  = 4'hF;
    localparam int         GATE_BIT   = 0;
    localparam int         ACCENT_BIT = 7;
    localparam int         NOTE_W     = 4;
    localparam int         ADDR_W     = 6;
    localparam int         ENTRY_W    = 2 * (NOTE_W + 1);
    localparam int         TC_W       = 20;

    typedef enum logic {STOPPED, RUNNING} state_t;

    typedef struct packed {
        logic              acc1;
        logic [NOTE_W-1:0] n1;
        logic              acc2;
        logic [NOTE_W-1:0] n2;
    } entry_t;

    function automatic logic [8:0] tri_wave(input logic [9:0] p);
        return p[9] ? ~p[8:0] : p[8:0];
    endfunction
endpackage

// File: rtl/pattern_rom.sv
// pattern_rom: combinational note/accent pattern, addressed by {bar, step}.
module pattern_rom
    import audio_seq_pkg::*;
(
    input  logic [ADDR_W-1:0]  addr,
    output logic [ENTRY_W-1:0] data
);
    always_comb begin
        data = {addr[0] & addr[3], {addr[1:0], addr[5:4]} ^ addr[3:0],
                addr[2] ^ addr[4], addr[3:0] + {2'b00, addr[5:4]}};
        case (addr)
            6'd0:    data = 10'h000;
            6'd1:    data = 10'h1E2;
            6'd15:   data = 10'h2E3;
            6'd16:   data = 10'h0A4;
            default: ;
        endcase
    end
endmodule

// File: rtl/voice_sequencer.sv
// voice_sequencer: two-voice step sequencer with tempo, gating and pulse-width sweep.
module voice_sequencer
    import audio_seq_pkg::*;
#(
    parameter int          STEP_TICKS = 131072,
    parameter int          GATE_TICKS = 65536,
    parameter logic [5:0]  WAVE1      = 6'b101000,
    parameter logic [5:0]  WAVE2      = 6'b100000,
    parameter logic [11:0] PW_BASE    = 12'd512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        start,
    input  logic        stop,
    output logic        running,
    output logic [3:0]  step,
    output logic [1:0]  bar,
    output logic        step_strobe,
    output logic [3:0]  note1,
    output logic [3:0]  note2,
    output logic [7:0]  control1,
    output logic [7:0]  control2,
    output logic [11:0] pulsewidth1,
    output logic [11:0] pulsewidth2
);
    state_t            state, state_n;
    logic [TC_W-1:0]   tc, tc_n;
    logic [9:0]        pw_div, pw_div_n, pw_cnt, pw_cnt_n;
    logic [3:0]        step_n, note1_n, note2_n;
    logic [1:0]        bar_n;
    logic              load, acc1_n, acc2_n, gate1_n, gate2_n;
    logic [ENTRY_W-1:0] rom_data;
    entry_t            ent;
    logic [8:0]        tri_n;

    pattern_rom u_rom (.addr({bar_n, step_n}), .data(rom_data));

    assign ent = entry_t'(rom_data);

    always_comb begin
        state_n  = state;
        tc_n     = tc;
        step_n   = step;
        bar_n    = bar;
        pw_div_n = pw_div;
        pw_cnt_n = pw_cnt;
        load     = 1'b0;
        if (state == STOPPED) begin
            if (start && !stop) begin
                state_n = RUNNING;
                tc_n    = '0;
                step_n  = '0;
                bar_n   = '0;
                load    = 1'b1;
            end
        end else if (stop) begin
            state_n  = STOPPED;
            tc_n     = '0;
            step_n   = '0;
            bar_n    = '0;
            pw_div_n = '0;
            pw_cnt_n = '0;
        end else if (tick) begin
            pw_div_n = pw_div + 10'd1;
            pw_cnt_n = (pw_div == 10'h3FF) ? pw_cnt + 10'd1 : pw_cnt;
            if (tc == TC_W'(STEP_TICKS - 1)) begin
                tc_n   = '0;
                step_n = step + 4'd1;
                bar_n  = (step == 4'hF) ? bar + 2'd1 : bar;
                load   = 1'b1;
            end else begin
                tc_n = tc + TC_W'(1);
            end
        end
    end

    // Outputs are registered from next-state values so they settle on the same edge as the state.
    always_comb begin
        {acc1_n, note1_n, acc2_n, note2_n} = {control1[ACCENT_BIT], note1, control2[ACCENT_BIT], note2};
        if (state_n == STOPPED)
            {acc1_n, note1_n, acc2_n, note2_n} = '0;
        else if (load)
            {acc1_n, note1_n, acc2_n, note2_n} = {ent.acc1, ent.n1, ent.acc2, ent.n2};
        gate1_n = (state_n == RUNNING) && (tc_n < TC_W'(GATE_TICKS)) && (note1_n != REST_NOTE);
        gate2_n = (state_n == RUNNING) && (tc_n < TC_W'(GATE_TICKS)) && (note2_n != REST_NOTE);
        tri_n   = tri_wave(pw_cnt_n);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= STOPPED;
            tc          <= '0;
            pw_div      <= '0;
            pw_cnt      <= '0;
            running     <= 1'b0;
            step        <= '0;
            bar         <= '0;
            step_strobe <= 1'b0;
            note1       <= '0;
            note2       <= '0;
            control1    <= {1'b0, WAVE1, 1'b0};
            control2    <= {1'b0, WAVE2, 1'b0};
            pulsewidth1 <= PW_BASE;
            pulsewidth2 <= PW_BASE;
        end else begin
            state       <= state_n;
            tc          <= tc_n;
            pw_div      <= pw_div_n;
            pw_cnt      <= pw_cnt_n;
            running     <= state_n == RUNNING;
            step        <= step_n;
            bar         <= bar_n;
            step_strobe <= load;
            note1       <= note1_n;
            note2       <= note2_n;
            control1    <= {acc1_n, WAVE1, gate1_n};
            control2    <= {acc2_n, WAVE2, gate2_n};
            pulsewidth1 <= PW_BASE + 12'(tri_n);
            pulsewidth2 <= PW_BASE + 12'(tri_n >> 1);
        end
    end
endmodule
